// File: rtl/thread_dispatcher.sv
// thread_dispatcher: FIFO-buffered job dispatcher feeding a multi-thread core round-robin.
// Optional per-slot watchdog is compiled in with DISPATCH_TIMEOUT_EN.

module thread_dispatcher_slot #(
  parameter int JOB_ID_WIDTH   = 8,
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    grant,
  input  logic                    done,
  input  logic                    accept,
  input  logic [JOB_ID_WIDTH-1:0] id_in,
  output logic                    is_free,
  output logic                    is_done,
  output logic                    is_to,
  output logic [JOB_ID_WIDTH-1:0] id
);
  typedef enum logic [1:0] {S_FREE, S_START, S_RUN, S_DONE} state_t;
  state_t state, state_nxt;
  logic   to_hit;

`ifdef DISPATCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt;
  logic          to_q;

  // Counter is 0 on the first RUN cycle; the slot leaves RUN on the edge where it reaches T-1.
  always_ff @(posedge clk) begin
    if (reset || state != S_RUN) cnt <= '0;
    else                         cnt <= cnt + CW'(1);
  end

  assign to_hit = (state == S_RUN) && (cnt == CW'(TIMEOUT_CYCLES - 2));

  always_ff @(posedge clk) begin
    if (reset)                 to_q <= 1'b0;
    else if (state == S_RUN)   to_q <= to_hit && !done;
  end

  assign is_to = to_q && (state == S_DONE);
`else
  wire unused_timeout = (TIMEOUT_CYCLES != 0);
  assign to_hit = 1'b0;
  assign is_to  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_FREE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FREE:  if (grant) state_nxt = S_START;
      S_START: state_nxt = S_RUN;
      S_RUN:   if (done || to_hit) state_nxt = S_DONE;
      S_DONE:  if (accept) state_nxt = S_FREE;
      default: state_nxt = S_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)                          id <= '0;
    else if (grant && state == S_FREE)  id <= id_in;
  end

  assign is_free = (state == S_FREE);
  assign is_done = (state == S_DONE);
endmodule

module thread_dispatcher #(
  parameter int NUM_THREADS_PER_CORE = 4,
  parameter int JOB_ID_WIDTH         = 8,
  parameter int FIFO_DEPTH           = 8,
  parameter int TIMEOUT_CYCLES       = 2048
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    job_valid,
  input  logic [JOB_ID_WIDTH-1:0]                 job_id,
  output logic                                    job_ready,
  output logic [NUM_THREADS_PER_CORE-1:0]         start_thread,
  input  logic [NUM_THREADS_PER_CORE-1:0]         thread_busy,
  input  logic [NUM_THREADS_PER_CORE-1:0]         thread_done,
  output logic                                    cmpl_valid,
  output logic [JOB_ID_WIDTH-1:0]                 cmpl_id,
  output logic [$clog2(NUM_THREADS_PER_CORE)-1:0] cmpl_thread,
  output logic                                    cmpl_timeout,
  input  logic                                    cmpl_ready,
  output logic [$clog2(FIFO_DEPTH):0]             pending,
  output logic                                    idle
);
  localparam int NT = NUM_THREADS_PER_CORE;
  localparam int TW = $clog2(NT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic [JOB_ID_WIDTH-1:0] id;
    logic [TW-1:0]           thr;
    logic                    to;
  } cmpl_t;

  // FIFO
  logic [JOB_ID_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [PW-1:0]           count;
  logic                    push, pop;

  assign job_ready = (count < PW'(FIFO_DEPTH));
  assign push      = job_valid && job_ready;
  assign pending   = count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= job_id;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + PW'(push) - PW'(pop);
    end
  end

  // Slots
  logic [NT-1:0]                   slot_free, slot_done, slot_to, elig, grant, accept;
  logic [NT-1:0][JOB_ID_WIDTH-1:0] slot_id;

  for (genvar g = 0; g < NT; g++) begin : g_slot
    thread_dispatcher_slot #(
      .JOB_ID_WIDTH  (JOB_ID_WIDTH),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_slot (
      .clk    (clk),
      .reset  (reset),
      .grant  (grant[g]),
      .done   (thread_done[g]),
      .accept (accept[g]),
      .id_in  (mem[rd_ptr]),
      .is_free(slot_free[g]),
      .is_done(slot_done[g]),
      .is_to  (slot_to[g]),
      .id     (slot_id[g])
    );
  end

  // Round-robin dispatch, searching upward from rr_ptr
  logic [TW-1:0] rr_ptr, pick, cand;
  logic          found, dispatch;
  int            idx;

  assign elig = slot_free & ~thread_busy;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    idx   = 0;
    for (int k = 0; k < NT; k++) begin
      idx  = (int'(rr_ptr) + k) % NT;
      cand = TW'(idx);
      if (!found && elig[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign dispatch     = found && (count != '0) && !reset;
  assign pop          = dispatch;
  assign grant        = dispatch ? (NT'(1) << pick) : '0;
  assign start_thread = grant;

  always_ff @(posedge clk) begin
    if (reset)         rr_ptr <= '0;
    else if (dispatch) rr_ptr <= (int'(pick) == NT - 1) ? '0 : pick + TW'(1);
  end

  // Completion: lowest DONE slot, but a stalled record stays put until accepted
  logic [TW-1:0] low, sel, sel_q;
  logic          lock_q;
  cmpl_t         rec;

  always_comb begin
    low = '0;
    for (int k = NT - 1; k >= 0; k--) begin
      if (slot_done[k]) low = TW'(k);
    end
  end

  assign sel        = lock_q ? sel_q : low;
  assign cmpl_valid = slot_done[sel] && !reset;
  assign accept     = (cmpl_valid && cmpl_ready) ? (NT'(1) << sel) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q <= 1'b0;
      sel_q  <= '0;
    end else begin
      lock_q <= cmpl_valid && !cmpl_ready;
      sel_q  <= sel;
    end
  end

  assign rec          = '{id: slot_id[sel], thr: sel, to: slot_to[sel] && cmpl_valid};
  assign cmpl_id      = rec.id;
  assign cmpl_thread  = rec.thr;
  assign cmpl_timeout = rec.to;

  assign idle = (count == '0) && (&slot_free);
endmodule

// File: tb/tb_thread_dispatcher.sv
// Directed bench for thread_dispatcher; completions are checked against a scoreboard queue.
module tb_thread_dispatcher;
  logic       clk, reset;
  logic       job_valid, job_ready;
  logic [7:0] job_id;
  logic [3:0] start_thread, thread_busy, thread_done;
  logic       cmpl_valid, cmpl_timeout, cmpl_ready, idle;
  logic [7:0] cmpl_id;
  logic [1:0] cmpl_thread;
  logic [3:0] pending;

  typedef struct { logic [7:0] id; logic [1:0] thr; logic to; } exp_t;
  exp_t sb[$];

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  thread_dispatcher #(
    .NUM_THREADS_PER_CORE(4), .JOB_ID_WIDTH(8), .FIFO_DEPTH(8), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .job_valid(job_valid), .job_id(job_id), .job_ready(job_ready),
    .start_thread(start_thread), .thread_busy(thread_busy), .thread_done(thread_done),
    .cmpl_valid(cmpl_valid), .cmpl_id(cmpl_id), .cmpl_thread(cmpl_thread),
    .cmpl_timeout(cmpl_timeout), .cmpl_ready(cmpl_ready), .pending(pending), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic expect_cmpl(input logic [7:0] id, input logic [1:0] thr, input logic to);
    exp_t e;
    e.id = id; e.thr = thr; e.to = to;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    nxt(); nxt();
    reset = 1'b0;
  endtask

  // Scoreboard: every accepted completion must match the oldest expectation
  always @(negedge clk) begin
    if (!reset && cmpl_valid && cmpl_ready) begin
      chk("cmpl_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("cmpl_id", 32'(cmpl_id), 32'(e.id));
        chk("cmpl_thread", 32'(cmpl_thread), 32'(e.thr));
        chk("cmpl_timeout", 32'(cmpl_timeout), 32'(e.to));
      end
    end
  end

  initial begin
    reset = 1'b1; job_valid = 1'b0; job_id = 8'h00;
    thread_busy = 4'h0; thread_done = 4'h0; cmpl_ready = 1'b1;
    nxt(); nxt(); nxt();
    settle();
    chk("rst_start", 32'(start_thread), 32'h0);
    chk("rst_cmpl_valid", 32'(cmpl_valid), 32'h0);
    reset = 1'b0;
    settle();
    chk("rst_job_ready", 32'(job_ready), 32'h1);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_idle", 32'(idle), 32'h1);
    chk("rst_timeout", 32'(cmpl_timeout), 32'h0);

    // Single job
    job_valid = 1'b1; job_id = 8'h5A;
    settle();
    chk("single_ready", 32'(job_ready), 32'h1);
    chk("single_start_early", 32'(start_thread), 32'h0);
    nxt(); job_valid = 1'b0; settle();
    chk("single_start", 32'(start_thread), 32'h1);
    chk("single_pending", 32'(pending), 32'h1);
    chk("single_busy_idle", 32'(idle), 32'h0);
    expect_cmpl(8'h5A, 2'd0, 1'b0);
    nxt(); settle();
    chk("single_start_once", 32'(start_thread), 32'h0);
    repeat (9) nxt();
    thread_done = 4'b0001; settle();
    chk("single_no_cmpl_yet", 32'(cmpl_valid), 32'h0);
    nxt(); thread_done = 4'b0000; settle();
    chk("single_cmpl_valid", 32'(cmpl_valid), 32'h1);
    chk("single_cmpl_id", 32'(cmpl_id), 32'h5A);
    nxt(); settle();
    chk("single_idle", 32'(idle), 32'h1);
    chk("single_cmpl_clear", 32'(cmpl_valid), 32'h0);

    // Fill and backpressure
    do_reset();
    thread_busy = 4'hF;
    for (int i = 0; i < 9; i++) begin
      job_valid = 1'b1; job_id = 8'(8'h10 + i);
      settle();
      chk($sformatf("fill_ready_%0d", i), 32'(job_ready), (i < 8) ? 32'h1 : 32'h0);
      nxt();
    end
    job_valid = 1'b0;
    settle();
    chk("fill_pending", 32'(pending), 32'h8);
    chk("fill_not_ready", 32'(job_ready), 32'h0);
    thread_busy = 4'h0;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk($sformatf("drain_start_%0d", k), 32'(start_thread), 32'h1 << k);
      nxt();
    end
    settle();
    chk("drain_stop", 32'(start_thread), 32'h0);
    chk("drain_pending", 32'(pending), 32'h4);

    // Round-robin: slot 0 finishes first and takes the 5th and 6th jobs
    thread_done = 4'b0001; expect_cmpl(8'h10, 2'd0, 1'b0);
    nxt(); thread_done = 4'b0000; settle();
    chk("rr_no_start_in_done", 32'(start_thread), 32'h0);
    nxt(); settle();
    chk("rr_5th_slot0", 32'(start_thread), 32'h1);
    nxt(); nxt();
    thread_done = 4'b0001; expect_cmpl(8'h14, 2'd0, 1'b0);
    nxt(); thread_done = 4'b0000;
    nxt(); settle();
    chk("rr_6th_slot0", 32'(start_thread), 32'h1);
    nxt(); thread_busy = 4'hF;
    nxt();
    thread_done = 4'b0101;
    expect_cmpl(8'h15, 2'd0, 1'b0);
    expect_cmpl(8'h12, 2'd2, 1'b0);
    nxt(); thread_done = 4'b0000;
    nxt(); nxt(); settle();
    chk("rr_busy_blocks", 32'(start_thread), 32'h0);
    thread_busy = 4'h0; settle();
    chk("rr_from_ptr1", 32'(start_thread), 32'h4);
    nxt(); settle();
    chk("rr_wrap_slot0", 32'(start_thread), 32'h1);
    nxt(); settle();
    chk("rr_fifo_empty", 32'(pending), 32'h0);
    chk("rr_no_start", 32'(start_thread), 32'h0);

    // Simultaneous done on slots 1 and 3 with a stalled consumer
    nxt(); nxt();
    thread_done = 4'b1010; cmpl_ready = 1'b0;
    expect_cmpl(8'h11, 2'd1, 1'b0);
    expect_cmpl(8'h13, 2'd3, 1'b0);
    for (int c = 0; c < 3; c++) begin
      nxt(); thread_done = 4'b0000; settle();
      chk($sformatf("hold_valid_%0d", c), 32'(cmpl_valid), 32'h1);
      chk($sformatf("hold_thread_%0d", c), 32'(cmpl_thread), 32'h1);
      chk($sformatf("hold_id_%0d", c), 32'(cmpl_id), 32'h11);
    end
    nxt(); cmpl_ready = 1'b1; settle();
    chk("accept_thread", 32'(cmpl_thread), 32'h1);
    nxt(); settle();
    chk("follow_valid", 32'(cmpl_valid), 32'h1);
    chk("follow_thread", 32'(cmpl_thread), 32'h3);
    chk("follow_id", 32'(cmpl_id), 32'h13);
    nxt(); settle();
    chk("follow_clear", 32'(cmpl_valid), 32'h0);

    // Reset mid-run: slots 0 and 2 in RUN, three jobs queued
    thread_busy = 4'hF;
    for (int i = 0; i < 3; i++) begin
      job_valid = 1'b1; job_id = 8'(8'h20 + i);
      nxt();
    end
    job_valid = 1'b0; settle();
    chk("mid_pending", 32'(pending), 32'h3);
    chk("mid_not_idle", 32'(idle), 32'h0);
    reset = 1'b1; settle();
    chk("mid_rst_start", 32'(start_thread), 32'h0);
    chk("mid_rst_cmpl", 32'(cmpl_valid), 32'h0);
    nxt(); nxt();
    reset = 1'b0; thread_busy = 4'h0; thread_done = 4'hF;
    for (int c = 0; c < 5; c++) begin
      settle();
      chk($sformatf("post_rst_cmpl_%0d", c), 32'(cmpl_valid), 32'h0);
      chk($sformatf("post_rst_idle_%0d", c), 32'(idle), 32'h1);
      chk($sformatf("post_rst_start_%0d", c), 32'(start_thread), 32'h0);
      nxt();
    end
    thread_done = 4'h0;
    settle();
    chk("post_rst_pending", 32'(pending), 32'h0);
    chk("post_rst_ready", 32'(job_ready), 32'h1);

    // Core that never signals done
    job_valid = 1'b1; job_id = 8'h33;
    nxt(); job_valid = 1'b0; settle();
    chk("hang_start", 32'(start_thread), 32'h1);
`ifdef DISPATCH_TIMEOUT_EN
    expect_cmpl(8'h33, 2'd0, 1'b1);
    for (int c = 1; c <= 16; c++) begin
      nxt(); settle();
      chk($sformatf("to_wait_%0d", c), 32'(cmpl_valid), 32'h0);
    end
    nxt(); settle();
    chk("to_valid", 32'(cmpl_valid), 32'h1);
    chk("to_flag", 32'(cmpl_timeout), 32'h1);
    nxt(); settle();
    chk("to_idle", 32'(idle), 32'h1);
`else
    repeat (40) nxt();
    settle();
    chk("hang_no_cmpl", 32'(cmpl_valid), 32'h0);
    chk("hang_not_idle", 32'(idle), 32'h0);
    chk("hang_timeout", 32'(cmpl_timeout), 32'h0);
    do_reset();
`endif

    nxt(); nxt();
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
